// File: rtl/store_narrow.sv
// Store-path narrowing unit: lane-places byte/half/word stores, flags range overflow, buffers entries in a FIFO.
// Optional feature macro: STORE_MISALIGN_EN (flags misaligned half/word stores and suppresses their byte enables).
module store_narrow #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_addr,
    input  logic [31:0]                in_data,
    input  logic [1:0]                 in_size,
    input  logic                       in_unsigned,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_addr,
    output logic [31:0]                out_data,
    output logic [3:0]                 out_be,
    output logic                       out_ovf,
    output logic                       out_misalign,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [CW-1:0] r_count;

    logic [29:0] r_addrMem [DEPTH];
    logic [31:0] r_dataMem [DEPTH];
    logic [3:0]  r_beMem   [DEPTH];
    logic        r_ovfMem  [DEPTH];
`ifdef STORE_MISALIGN_EN
    logic        r_misMem  [DEPTH];
`endif

    logic        w_push;
    logic        w_pop;
    logic [31:0] w_data;
    logic [3:0]  w_be;
    logic        w_ovf;
    logic        w_misalign;

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign out_valid = (r_count != '0);
    assign in_ready  = (r_count < CW'(DEPTH)) || out_ready;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign count     = r_count;

    // Signed fit: bits above the sign bit all match it, i.e. the upper slice is all ones or all zeros.
    always_comb begin
        w_data     = in_data;
        w_be       = 4'b0000;
        w_ovf      = 1'b0;
        w_misalign = 1'b0;
        case (in_size)
            2'b00: begin
                w_data = {4{in_data[7:0]}};
                w_be   = 4'b0001 << in_addr[1:0];
                w_ovf  = in_unsigned ? (|in_data[31:8])
                                     : !((&in_data[31:7]) || !(|in_data[31:7]));
            end
            2'b01: begin
                w_data = {2{in_data[15:0]}};
                w_be   = in_addr[1] ? 4'b1100 : 4'b0011;
                w_ovf  = in_unsigned ? (|in_data[31:16])
                                     : !((&in_data[31:15]) || !(|in_data[31:15]));
`ifdef STORE_MISALIGN_EN
                if (in_addr[0]) begin
                    w_misalign = 1'b1;
                    w_be       = 4'b0000;
                end
`endif
            end
            2'b10: begin
                w_be = 4'b1111;
`ifdef STORE_MISALIGN_EN
                if (in_addr[1:0] != 2'b00) begin
                    w_misalign = 1'b1;
                    w_be       = 4'b0000;
                end
`endif
            end
            default: begin
                w_be = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_pop)  r_rdPtr <= nextPtr(r_rdPtr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage needs no reset: stale contents are never visible because outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addrMem[r_wrPtr] <= in_addr[31:2];
            r_dataMem[r_wrPtr] <= w_data;
            r_beMem[r_wrPtr]   <= w_be;
            r_ovfMem[r_wrPtr]  <= w_ovf;
`ifdef STORE_MISALIGN_EN
            r_misMem[r_wrPtr]  <= w_misalign;
`endif
        end
    end

    assign out_addr = out_valid ? {r_addrMem[r_rdPtr], 2'b00} : 32'h0;
    assign out_data = out_valid ? r_dataMem[r_rdPtr] : 32'h0;
    assign out_be   = out_valid ? r_beMem[r_rdPtr] : 4'b0000;
    assign out_ovf  = out_valid ? r_ovfMem[r_rdPtr] : 1'b0;
`ifdef STORE_MISALIGN_EN
    assign out_misalign = out_valid ? r_misMem[r_rdPtr] : 1'b0;
`else
    assign out_misalign = 1'b0 & w_misalign;
`endif

endmodule

// File: tb/tb_store_narrow.sv
// Scoreboard bench for store_narrow: directed cases plus randomized stores against an arithmetic reference model.
// Honours STORE_MISALIGN_EN the same way as the design build.
module tb_store_narrow;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [1:0]  in_size;
    logic        in_unsigned;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic [3:0]  out_be;
    logic        out_ovf;
    logic        out_misalign;
    logic [1:0]  count;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        ovf;
        logic        mis;
    } expT;

    expT sbQ[$];

    store_narrow #(.DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data), .in_size(in_size), .in_unsigned(in_unsigned),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
        .out_ovf(out_ovf), .out_misalign(out_misalign), .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic expT mk(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                               input logic ovf, input logic mis);
        expT e;
        e.addr = a; e.data = d; e.be = be; e.ovf = ovf; e.mis = mis;
        return e;
    endfunction

    // Reference model: value ranges and lane replication expressed as plain arithmetic.
    function automatic expT modelStore(input logic [31:0] a, input logic [31:0] d,
                                       input logic [1:0] sz, input logic u);
        expT    e;
        longint sv;
        int     lane;
        sv     = longint'($signed(d));
        lane   = int'(a % 4);
        e.addr = a & 32'hFFFF_FFFC;
        e.data = d;
        e.be   = 4'h0;
        e.ovf  = 1'b0;
        e.mis  = 1'b0;
        case (sz)
            2'd0: begin
                e.data = (d & 32'h0000_00FF) * 32'h0101_0101;
                e.be   = 4'(1 << lane);
                e.ovf  = u ? (d > 32'd255) : (sv < -128 || sv > 127);
            end
            2'd1: begin
                e.data = (d & 32'h0000_FFFF) * 32'h0001_0001;
                e.be   = (lane >= 2) ? 4'hC : 4'h3;
                e.ovf  = u ? (d > 32'd65535) : (sv < -32768 || sv > 32767);
`ifdef STORE_MISALIGN_EN
                if (lane % 2 != 0) begin e.mis = 1'b1; e.be = 4'h0; end
`endif
            end
            2'd2: begin
                e.be = 4'hF;
`ifdef STORE_MISALIGN_EN
                if (lane != 0) begin e.mis = 1'b1; e.be = 4'h0; end
`endif
            end
            default: e.be = 4'h0;
        endcase
        return e;
    endfunction

    // Monitor: every accepted output beat is compared against the oldest expected entry.
    always @(negedge clk) begin : monitor
        expT e;
        if (!reset && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL unexpectedOutput: got addr %h data %h, expected no entry", out_addr, out_data);
            end else begin
                e = sbQ.pop_front();
                checkOutput("outAddr", out_addr, e.addr);
                checkOutput("outData", out_data, e.data);
                checkOutput("outBe", 32'(out_be), 32'(e.be));
                checkOutput("outOvf", 32'(out_ovf), 32'(e.ovf));
                checkOutput("outMisalign", 32'(out_misalign), 32'(e.mis));
            end
        end
    end

    // Drives one request and holds it until accepted; called at posedge+1, returns at posedge+1.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                                 input logic u, input expT e, input bit randReady, output int stalls);
        bit accepted;
        accepted = 0;
        stalls = 0;
        in_valid = 1'b1; in_addr = a; in_data = d; in_size = sz; in_unsigned = u;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sbQ.push_back(e);
                accepted = 1;
                break;
            end
            stalls++;
            @(posedge clk); #1;
            if (randReady) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (!accepted) begin
            nChecks++;
            $display("[TB] FAIL acceptTimeout: got no in_ready within 64 cycles, expected acceptance");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sbQ.size() != 0; i++) @(negedge clk);
        @(posedge clk); #1;
        checkOutput({name, "QueueEmpty"}, 32'(sbQ.size()), 32'd0);
        checkOutput({name, "Count"}, 32'(count), 32'd0);
    endtask

    initial begin
        int          st;
        expT         e;
        logic [31:0] a, d;
        logic [1:0]  sz;
        logic        u;

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_addr = '0; in_data = '0; in_size = '0; in_unsigned = 1'b0;
        #12;
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstCount", 32'(count), 32'd0);
        checkOutput("rstOutAddr", out_addr, 32'd0);
        checkOutput("rstOutData", out_data, 32'd0);
        checkOutput("rstOutBe", 32'(out_be), 32'd0);
        checkOutput("rstOutOvf", 32'(out_ovf), 32'd0);
        checkOutput("rstOutMisalign", 32'(out_misalign), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("idleInReady", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Directed cases with hand-computed expectations.
        out_ready = 1'b1;
        applyStimulus(32'h0000_1003, 32'hFFFF_FFF8, 2'b00, 1'b0,
                      mk(32'h0000_1000, 32'hF8F8_F8F8, 4'b1000, 1'b0, 1'b0), 0, st);
        applyStimulus(32'h0000_0002, 32'h0000_8000, 2'b01, 1'b0,
                      mk(32'h0000_0000, 32'h8000_8000, 4'b1100, 1'b1, 1'b0), 0, st);
        applyStimulus(32'h0000_0002, 32'h0000_8000, 2'b01, 1'b1,
                      mk(32'h0000_0000, 32'h8000_8000, 4'b1100, 1'b0, 1'b0), 0, st);
`ifdef STORE_MISALIGN_EN
        applyStimulus(32'h0000_0006, 32'h1234_5678, 2'b10, 1'b0,
                      mk(32'h0000_0004, 32'h1234_5678, 4'b0000, 1'b0, 1'b1), 0, st);
`else
        applyStimulus(32'h0000_0006, 32'h1234_5678, 2'b10, 1'b0,
                      mk(32'h0000_0004, 32'h1234_5678, 4'b1111, 1'b0, 1'b0), 0, st);
`endif
        applyStimulus(32'h0000_0010, 32'h0000_0007, 2'b11, 1'b0,
                      mk(32'h0000_0010, 32'h0000_0007, 4'b0000, 1'b0, 1'b0), 0, st);
        waitDrain("directed");

        // Sustained throughput: with out_ready high every request is taken without a stall.
        for (int i = 0; i < 4; i++) begin
            a = $urandom; d = $urandom; sz = 2'($urandom_range(0, 3)); u = 1'($urandom_range(0, 1));
            applyStimulus(a, d, sz, u, modelStore(a, d, sz, u), 0, st);
            checkOutput("throughputStalls", 32'(st), 32'd0);
        end
        waitDrain("throughput");

        // Backpressure: two entries fill the buffer, the third waits until a pop frees a slot.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 32'h100 + 32'(4 * i); d = 32'(i + 1);
            applyStimulus(a, d, 2'b10, 1'b0, modelStore(a, d, 2'b10, 1'b0), 0, st);
        end
        in_valid = 1'b1; in_addr = 32'h0000_0201; in_data = 32'h0000_00AB; in_size = 2'b00; in_unsigned = 1'b1;
        @(negedge clk);
        checkOutput("fullInReady", 32'(in_ready), 32'd0);
        checkOutput("fullCount", 32'(count), 32'd2);
        @(posedge clk); #1;
        checkOutput("fullHeadHeld", out_data, 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("popCycleInReady", 32'(in_ready), 32'd1);
        sbQ.push_back(modelStore(32'h0000_0201, 32'h0000_00AB, 2'b00, 1'b1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("pushPopCount", 32'(count), 32'd2);
        waitDrain("backpressure");

        // Reset between edges while full, then a fresh push appears one cycle later.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = $urandom; d = $urandom;
            applyStimulus(a, d, 2'b01, 1'b0, modelStore(a, d, 2'b01, 1'b0), 0, st);
        end
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
        checkOutput("midRstCount", 32'(count), 32'd0);
        checkOutput("midRstOutBe", 32'(out_be), 32'd0);
        sbQ.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_addr = 32'h0000_0300; in_data = 32'hFFFF_FF80; in_size = 2'b00; in_unsigned = 1'b0;
        @(negedge clk);
        checkOutput("postRstInReady", 32'(in_ready), 32'd1);
        checkOutput("noBypass", 32'(out_valid), 32'd0);
        sbQ.push_back(mk(32'h0000_0300, 32'h8080_8080, 4'b0001, 1'b0, 1'b0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("postRstLatency", 32'(out_valid), 32'd1);
        waitDrain("reset");

        // Randomized traffic with random backpressure; data biased toward narrow-range values.
        for (int i = 0; i < 200; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            a = $urandom;
            case ($urandom_range(0, 2))
                0:       d = $urandom;
                1:       begin d = 32'($urandom_range(0, 255));   if (d[7])  d = d | 32'hFFFF_FF00; if ($urandom_range(0, 1) == 1) d = d ^ 32'h0000_0100; end
                default: begin d = 32'($urandom_range(0, 65535)); if (d[15]) d = d | 32'hFFFF_0000; end
            endcase
            sz = 2'($urandom_range(0, 3));
            u  = 1'($urandom_range(0, 1));
            applyStimulus(a, d, sz, u, modelStore(a, d, sz, u), 1, st);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        waitDrain("random");

        $display("[TB] %0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
